gpio_ctrl: RTL and testbench

- Memory-mapped GPIO peripheral; the responder on the `gpio_*` valid/ready port driven by the interconnect subsystem.
- Holds output-data and direction registers and synchronises pad inputs.
- Optionally detects input edges into sticky interrupt status, which raises a level interrupt.
- Sits at the leaf of the interconnect.

---
 rtl/gpio_ctrl.sv | 157 +++++++++++++++
 tb/tb_gpio_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO responder on a valid/ready port.
// Holds DATA_OUT and DIR, synchronises pad inputs into DATA_IN, and,
// when GPIO_IRQ_EN is defined, detects input edges into sticky
// IRQ_STATUS that drives a level interrupt. Without GPIO_IRQ_EN the
// interrupt registers are absent, read as 0 and gpio_irq is tied low.
module gpio_ctrl #(
  parameter int NUM_GPIO = 32
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                gpio_valid,
  input  logic [23:0]         gpio_addr,
  input  logic                gpio_write,
  input  logic [31:0]         gpio_wdata,
  input  logic [3:0]          gpio_wstrb,
  output logic [31:0]         gpio_rdata,
  output logic                gpio_ready,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                gpio_irq
);

  localparam logic [2:0] REG_DATA_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR        = 3'd1;
  localparam logic [2:0] REG_DATA_IN    = 3'd2;
  localparam logic [2:0] REG_OUT_SET    = 3'd3;
  localparam logic [2:0] REG_OUT_CLR    = 3'd4;
  localparam logic [2:0] REG_IRQ_EN     = 3'd5;
  localparam logic [2:0] REG_IRQ_POL    = 3'd6;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd7;

  logic                accept;
  logic                in_range;
  logic                wr_en;
  logic [2:0]          sel;
  logic [31:0]         byte_mask;
  logic [31:0]         rd_mux;
  logic [NUM_GPIO-1:0] wmask;
  logic [NUM_GPIO-1:0] wbits;
  logic [NUM_GPIO-1:0] data_out;
  logic [NUM_GPIO-1:0] dir;
  logic [NUM_GPIO-1:0] sync_s1;
  logic [NUM_GPIO-1:0] sync_s2;
  logic                unused_bits;

  // The ready cycle itself never accepts, so a held valid cannot double-commit.
  assign accept    = gpio_valid && !gpio_ready;
  assign in_range  = (gpio_addr[23:5] == 19'd0);
  assign sel       = gpio_addr[4:2];
  assign wr_en     = accept && gpio_write && in_range;
  assign byte_mask = {{8{gpio_wstrb[3]}}, {8{gpio_wstrb[2]}},
                      {8{gpio_wstrb[1]}}, {8{gpio_wstrb[0]}}};
  assign wmask     = byte_mask[NUM_GPIO-1:0];
  assign wbits     = gpio_wdata[NUM_GPIO-1:0] & wmask;
  // Byte offset bits and bits above NUM_GPIO are intentionally dropped.
  assign unused_bits = ^{gpio_addr[1:0], gpio_wdata, byte_mask};

  assign gpio_out = data_out;
  assign gpio_oe  = dir;

`ifdef GPIO_IRQ_EN
  logic [NUM_GPIO-1:0] irq_en;
  logic [NUM_GPIO-1:0] irq_pol;
  logic [NUM_GPIO-1:0] irq_status;
  logic [NUM_GPIO-1:0] sync_s3;
  logic [NUM_GPIO-1:0] edge_det;

  // POL=0 selects rising edges, POL=1 falling edges, per bit.
  assign edge_det = (irq_pol & ~sync_s2 & sync_s3) | (~irq_pol & sync_s2 & ~sync_s3);
  assign gpio_irq = |(irq_status & irq_en);
`else
  assign gpio_irq = 1'b0;
`endif

  // Read mux over pre-edge register state; out-of-range addresses read 0.
  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      case (sel)
        REG_DATA_OUT, REG_OUT_SET, REG_OUT_CLR: rd_mux[NUM_GPIO-1:0] = data_out;
        REG_DIR:        rd_mux[NUM_GPIO-1:0] = dir;
        REG_DATA_IN:    rd_mux[NUM_GPIO-1:0] = sync_s2;
`ifdef GPIO_IRQ_EN
        REG_IRQ_EN:     rd_mux[NUM_GPIO-1:0] = irq_en;
        REG_IRQ_POL:    rd_mux[NUM_GPIO-1:0] = irq_pol;
        REG_IRQ_STATUS: rd_mux[NUM_GPIO-1:0] = irq_status;
`endif
        default:        rd_mux = '0;
      endcase
    end
  end

  // Registered one-cycle completion; rdata is zero outside the ready cycle.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_ready <= 1'b0;
      gpio_rdata <= '0;
    end else begin
      gpio_ready <= accept;
      gpio_rdata <= (accept && !gpio_write) ? rd_mux : 32'd0;
    end
  end

  // DATA_OUT: direct byte-masked write, write-1-set and write-1-clear views.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (wr_en) begin
      case (sel)
        REG_DATA_OUT: data_out <= (data_out & ~wmask) | wbits;
        REG_OUT_SET:  data_out <= data_out | wbits;
        REG_OUT_CLR:  data_out <= data_out & ~wbits;
        default:      data_out <= data_out;
      endcase
    end
  end

  // DIR register drives the pad output enables.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= '0;
    end else if (wr_en && (sel == REG_DIR)) begin
      dir <= (dir & ~wmask) | wbits;
    end
  end

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= gpio_in;
      sync_s2 <= sync_s1;
    end
  end

`ifdef GPIO_IRQ_EN
  // Edge history, interrupt config, and sticky status where a new edge beats a W1C.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s3    <= '0;
      irq_en     <= '0;
      irq_pol    <= '0;
      irq_status <= '0;
    end else begin
      sync_s3 <= sync_s2;
      if (wr_en && (sel == REG_IRQ_EN))  irq_en  <= (irq_en & ~wmask) | wbits;
      if (wr_en && (sel == REG_IRQ_POL)) irq_pol <= (irq_pol & ~wmask) | wbits;
      irq_status <= ((wr_en && (sel == REG_IRQ_STATUS)) ? (irq_status & ~wbits) : irq_status)
                    | edge_det;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: the driver pushes expected read data from a
// register-level model; a monitor pops and compares on every ready pulse.
module tb_gpio_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gpio_valid = 1'b0;
  logic [23:0] gpio_addr = '0;
  logic        gpio_write = 1'b0;
  logic [31:0] gpio_wdata = '0;
  logic [3:0]  gpio_wstrb = '0;
  logic [31:0] gpio_rdata;
  logic        gpio_ready;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        gpio_irq;

  gpio_ctrl #(.NUM_GPIO(32)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .gpio_valid (gpio_valid),
    .gpio_addr  (gpio_addr),
    .gpio_write (gpio_write),
    .gpio_wdata (gpio_wdata),
    .gpio_wstrb (gpio_wstrb),
    .gpio_rdata (gpio_rdata),
    .gpio_ready (gpio_ready),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .gpio_irq   (gpio_irq)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    logic [23:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Register-level reference model
  logic [31:0] m_out  = '0;
  logic [31:0] m_dir  = '0;
  logic [31:0] m_pins = '0;
  logic [31:0] m_en   = '0;
  logic [31:0] m_pol  = '0;
  logic [31:0] m_stat = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] m_read(input logic [23:0] a);
    if (a[23:5] != 0) return 32'd0;
    case (a[4:2])
      3'd0, 3'd3, 3'd4: return m_out;
      3'd1: return m_dir;
      3'd2: return m_pins;
`ifdef GPIO_IRQ_EN
      3'd5: return m_en;
      3'd6: return m_pol;
      3'd7: return m_stat;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    logic [31:0] v;
    m = bmask(s);
    v = d & m;
    if (a[23:5] == 0) begin
      case (a[4:2])
        3'd0: m_out = (m_out & ~m) | v;
        3'd1: m_dir = (m_dir & ~m) | v;
        3'd3: m_out = m_out | v;
        3'd4: m_out = m_out & ~v;
`ifdef GPIO_IRQ_EN
        3'd5: m_en = (m_en & ~m) | v;
        3'd6: m_pol = (m_pol & ~m) | v;
        3'd7: m_stat = m_stat & ~v;
`endif
        default: ;
      endcase
    end
  endfunction

  function automatic logic m_irq();
`ifdef GPIO_IRQ_EN
    return |(m_stat & m_en);
`else
    return 1'b0;
`endif
  endfunction

  // Pin change as seen by the model once it has crossed the synchroniser.
  function automatic void apply_pins(input logic [31:0] v);
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | ((v & ~m_pins) & ~m_pol) | ((~v & m_pins) & m_pol);
`endif
    m_pins = v;
  endfunction

  // Monitor: compare on every ready pulse, require zero rdata otherwise.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (gpio_ready) begin
        if (sb.size() == 0) begin
          check("spurious_ready", 32'(gpio_ready), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_read) check($sformatf("rdata@%06h", e.addr), gpio_rdata, e.exp);
        end
      end else begin
        check("rdata_idle", gpio_rdata, 32'd0);
      end
    end
  end

  // Called just after a negedge; returns just after a negedge.
  task automatic txn(input bit wr, input logic [23:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit chk_out);
    exp_t e;
    int   w;
    e.is_read = !wr;
    e.exp     = m_read(a);
    e.addr    = a;
    sb.push_back(e);
    gpio_valid = 1'b1;
    gpio_write = wr;
    gpio_addr  = a;
    gpio_wdata = d;
    gpio_wstrb = s;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("ready_latency", 32'(gpio_ready), 32'd1);
    w = 0;
    while (!gpio_ready && w < 4) begin
      @(negedge sys_clk);
      w++;
    end
    if (wr) m_write(a, d, s);
    if (chk_out) begin
      check("gpio_out", gpio_out, m_out);
      check("gpio_oe", gpio_oe, m_dir);
      check("gpio_irq", 32'(gpio_irq), 32'(m_irq()));
    end
    // valid stays high through the ready cycle's closing edge
    @(posedge sys_clk);
    #1;
    gpio_valid = 1'b0;
    gpio_write = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic set_pins(input logic [31:0] v);
    gpio_in = v;
    repeat (3) @(negedge sys_clk);
    apply_pins(v);
    check("irq_after_pins", 32'(gpio_irq), 32'(m_irq()));
  endtask

  initial begin
    logic [18:0] hi;
    logic [23:0] a;

    // Reset values
    repeat (3) @(negedge sys_clk);
    check("rst_out", gpio_out, 32'd0);
    check("rst_oe", gpio_oe, 32'd0);
    check("rst_irq", 32'(gpio_irq), 32'd0);
    check("rst_ready", 32'(gpio_ready), 32'd0);
    check("rst_rdata", gpio_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    txn(0, 24'h00, 0, 0, 1);
    txn(0, 24'h04, 0, 0, 1);
    txn(0, 24'h1C, 0, 0, 1);

    // Reset mid-transaction drops the pending ready
    gpio_valid = 1'b1;
    gpio_addr  = 24'h00;
    @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    gpio_valid = 1'b0;
    #1;
    check("rst_mid_ready", 32'(gpio_ready), 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Byte-masked write, W1S, W1C
    txn(1, 24'h00, 32'hA5A5_1234, 4'b0011, 1);
    check("bytemask_out", gpio_out, 32'h0000_1234);
    txn(1, 24'h0C, 32'hFF00_0000, 4'hF, 1);
    check("w1s_out", gpio_out, 32'hFF00_1234);
    txn(1, 24'h10, 32'h0000_0034, 4'hF, 1);
    check("w1c_out", gpio_out, 32'hFF00_1200);
    txn(0, 24'h0C, 0, 0, 1);
    txn(1, 24'h04, 32'h1234_5678, 4'b1100, 1);
    check("dir_mask", gpio_oe, 32'h1234_0000);
    txn(1, 24'h00, 32'hFFFF_FFFF, 4'b0000, 1);
    check("wstrb0_noop", gpio_out, 32'hFF00_1200);

    // Input sync: read accepted at E0 sees old, read accepted at E2 sees new
    gpio_in = 32'h0000_00F0;
    txn(0, 24'h08, 0, 0, 1);
    apply_pins(32'h0000_00F0);
    txn(0, 24'h08, 0, 0, 1);
    repeat (2) @(negedge sys_clk);

`ifdef GPIO_IRQ_EN
    // Rising-edge IRQ, W1C, and W1C coincident with a new edge
    txn(1, 24'h14, 32'h1, 4'hF, 1);
    txn(1, 24'h1C, 32'hFFFF_FFFF, 4'hF, 1);
    set_pins(m_pins | 32'h1);
    check("irq_rise", 32'(gpio_irq), 32'd1);
    txn(1, 24'h1C, 32'h1, 4'hF, 1);
    check("irq_w1c", 32'(gpio_irq), 32'd0);
    set_pins(m_pins & ~32'h1);
    set_pins(m_pins | 32'h1);
    set_pins(m_pins & ~32'h1);
    gpio_in = m_pins | 32'h1;
    repeat (2) @(negedge sys_clk);
    txn(1, 24'h1C, 32'h1, 4'hF, 0);
    apply_pins(m_pins | 32'h1);
    check("edge_beats_w1c", 32'(gpio_irq), 32'd1);
    txn(0, 24'h1C, 0, 0, 1);

    // Falling-edge IRQ with enable off, then on
    txn(1, 24'h14, 32'h0, 4'hF, 1);
    txn(1, 24'h1C, 32'hFFFF_FFFF, 4'hF, 1);
    txn(1, 24'h18, 32'h8, 4'hF, 1);
    set_pins(m_pins | 32'h8);
    set_pins(m_pins & ~32'h8);
    txn(0, 24'h1C, 0, 0, 1);
    check("fall_irq_off", 32'(gpio_irq), 32'd0);
    txn(1, 24'h14, 32'h8, 4'hF, 1);
    check("fall_irq_on", 32'(gpio_irq), 32'd1);
`else
    // Interrupt registers absent: read 0, irq stays low
    txn(1, 24'h14, 32'hFFFF_FFFF, 4'hF, 1);
    txn(1, 24'h18, 32'hFFFF_FFFF, 4'hF, 1);
    txn(0, 24'h14, 0, 0, 1);
    txn(0, 24'h18, 0, 0, 1);
    set_pins(32'h0000_000F);
    txn(0, 24'h1C, 0, 0, 1);
    check("irq_tied", 32'(gpio_irq), 32'd0);
`endif

    // Out-of-range address
    txn(1, 24'h00_0040, 32'hFFFF_FFFF, 4'hF, 1);
    txn(0, 24'h00_0040, 0, 0, 1);
    txn(1, 24'h80_0004, 32'hFFFF_FFFF, 4'hF, 1);
    txn(1, 24'h0C, 32'h0000_0001, 4'hF, 1);
    txn(0, 24'h00, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        set_pins($urandom);
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          hi = 19'($urandom_range(1, 19'h7FFFF));
          a  = {hi, 5'($urandom)};
        end else begin
          a = {19'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
        end
        txn(1'($urandom), a, $urandom, 4'($urandom), 1);
      end
    end

    repeat (3) @(negedge sys_clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
